fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 124 ++++++++++++
 tb/tb_fetch_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: requests a word at pc_cur, hands it to decode,
// then loads the PC register with either the sequential PC or a redirect target.
module fetch_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        update_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DELIVER,
        UPDATE,
        HALT
    } state_t;

    state_t      state;
    logic        redir_pending;
    logic [31:0] redir_target_q;
    logic [31:0] target_aligned;
    logic [31:0] pc_seq;

    // Instruction addresses are word aligned, so the low two bits are dropped.
    assign target_aligned = redirect_target & 32'hFFFF_FFFC;
    assign pc_seq         = (pc_cur + 32'd4) & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pc_next        <= 32'd0;
            update_pc      <= 1'b0;
            imem_req       <= 1'b0;
            imem_addr      <= 32'd0;
            instr          <= 32'd0;
            instr_valid    <= 1'b0;
            halted         <= 1'b0;
            fetch_count    <= 32'd0;
            redir_pending  <= 1'b0;
            redir_target_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect || redir_pending) begin
                        state         <= UPDATE;
                        update_pc     <= 1'b1;
                        pc_next       <= redirect ? target_aligned : redir_target_q;
                        redir_pending <= 1'b0;
                    end else if (halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_cur;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        redir_pending  <= 1'b1;
                        redir_target_q <= target_aligned;
                    end
                    // A redirected fetch still waits for its ack, then drops the word.
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (redirect || redir_pending) begin
                            state         <= UPDATE;
                            update_pc     <= 1'b1;
                            pc_next       <= redirect ? target_aligned : redir_target_q;
                            redir_pending <= 1'b0;
                        end else begin
                            state       <= DELIVER;
                            instr       <= imem_rdata;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                DELIVER: begin
                    if (redirect) begin
                        state       <= UPDATE;
                        instr_valid <= 1'b0;
                        update_pc   <= 1'b1;
                        pc_next     <= target_aligned;
                    end else if (instr_ready) begin
                        state       <= UPDATE;
                        instr_valid <= 1'b0;
                        update_pc   <= 1'b1;
                        pc_next     <= pc_seq;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                UPDATE: begin
                    state     <= IDLE;
                    update_pc <= 1'b0;
                    // A redirect landing here is replayed from IDLE.
                    if (redirect) begin
                        redir_pending  <= 1'b1;
                        redir_target_q <= target_aligned;
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus randomized
// transactions compared against a transaction-level PC/count model.
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        update_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt;
    logic        halted;
    logic [31:0] fetch_count;

    logic        pc_load_en;
    logic [31:0] pc_load_val;
    logic [31:0] pc_reg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_pc;
    logic [31:0] model_count;

    logic [31:0] obs_addr;
    logic [31:0] obs_instr;
    logic [31:0] obs_pc_next;
    int          obs_cycles;
    int          obs_stable_err;
    int          obs_valid_cnt;
    int          obs_upd_cnt;

    fetch_controller dut (
        .clk             (clk),
        .reset           (reset),
        .pc_cur          (pc_cur),
        .pc_next         (pc_next),
        .update_pc       (update_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in PC register: loads pc_next on update_pc, or a preset from the bench.
    always @(posedge clk) begin
        if (pc_load_en) pc_reg <= pc_load_val;
        else if (update_pc) pc_reg <= pc_next;
    end
    assign pc_cur = pc_reg;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_load(input logic [31:0] pc);
        reset = 1'b1; pc_load_en = 1'b1; pc_load_val = pc;
        imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
        step();
        reset = 1'b0; pc_load_en = 1'b0;
        model_pc = pc; model_count = 32'd0;
    endtask

    task automatic sample_pulses();
        if (update_pc === 1'b1) obs_upd_cnt++;
        if (instr_valid === 1'b1) obs_valid_cnt++;
    endtask

    // One fetch transaction from IDLE back to IDLE. mode: 0 plain, 1 redirect in
    // FETCH at cycle rc, 2 redirect together with ready, 3 two redirects in FETCH.
    task automatic drive_one(input int ack_dly, input int rdy_dly, input int mode,
                             input int rc, input logic [31:0] t1, input logic [31:0] t2);
        obs_cycles = 0; obs_stable_err = 0; obs_valid_cnt = 0; obs_upd_cnt = 0;
        obs_instr = 32'd0;
        imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
        step(); obs_cycles++;
        obs_addr = imem_addr;
        for (int k = 0; k <= ack_dly; k++) begin
            if (imem_req !== 1'b1 || imem_addr !== obs_addr) obs_stable_err++;
            sample_pulses();
            imem_ack   = (k == ack_dly);
            imem_rdata = (k == ack_dly) ? mem_word(imem_addr) : $urandom;
            if (mode == 1 && k == rc) begin redirect = 1'b1; redirect_target = t1; end
            if (mode == 3 && k == 0) begin redirect = 1'b1; redirect_target = t1; end
            if (mode == 3 && k == ack_dly) begin redirect = 1'b1; redirect_target = t2; end
            step(); obs_cycles++;
            imem_ack = 1'b0; redirect = 1'b0;
        end
        if (mode == 0 || mode == 2) begin
            obs_instr = instr;
            for (int j = 0; j <= rdy_dly; j++) begin
                if (instr_valid !== 1'b1 || instr !== obs_instr || imem_req !== 1'b0) obs_stable_err++;
                sample_pulses();
                instr_ready = (j == rdy_dly);
                if (mode == 2 && j == rdy_dly) begin redirect = 1'b1; redirect_target = t1; end
                step(); obs_cycles++;
                instr_ready = 1'b0; redirect = 1'b0;
            end
        end
        obs_pc_next = pc_next;
        sample_pulses();
        step(); obs_cycles++;
        sample_pulses();
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1; redirect = 1'b1;
        redirect_target = 32'h1234_5678; halt = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        pc_load_en = 1'b1; pc_load_val = 32'h0;
        step(); step();
        n_checks++; if (pc_next !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_pc_next: got %h want 0", pc_next); end
        n_checks++; if (update_pc !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_update_pc: got %b want 0", update_pc); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_imem_req: got %b want 0", imem_req); end
        n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_imem_addr: got %h want 0", imem_addr); end
        n_checks++; if (instr !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h want 0", instr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_instr_valid: got %b want 0", instr_valid); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_fetch_count: got %h want 0", fetch_count); end
    endtask

    task automatic test_sequential();
        reset_and_load(32'h100);
        drive_one(0, 0, 0, 0, 32'h0, 32'h0);
        n_checks++; if (obs_addr !== 32'h100) begin n_fail++; $display("[TB] FAIL seq_addr: got %h want %h", obs_addr, 32'h100); end
        n_checks++; if (obs_instr !== mem_word(32'h100)) begin n_fail++; $display("[TB] FAIL seq_instr: got %h want %h", obs_instr, mem_word(32'h100)); end
        n_checks++; if (obs_pc_next !== 32'h104) begin n_fail++; $display("[TB] FAIL seq_pc_next: got %h want %h", obs_pc_next, 32'h104); end
        n_checks++; if (fetch_count !== 32'd1) begin n_fail++; $display("[TB] FAIL seq_count: got %0d want 1", fetch_count); end
        n_checks++; if (obs_cycles !== 4) begin n_fail++; $display("[TB] FAIL seq_cycles: got %0d want 4", obs_cycles); end
        n_checks++; if (obs_upd_cnt !== 1) begin n_fail++; $display("[TB] FAIL seq_upd_pulses: got %0d want 1", obs_upd_cnt); end
        n_checks++; if (pc_cur !== 32'h104) begin n_fail++; $display("[TB] FAIL seq_pc_reg: got %h want %h", pc_cur, 32'h104); end
    endtask

    task automatic test_wait_states();
        reset_and_load(32'h2000);
        drive_one(3, 2, 0, 0, 32'h0, 32'h0);
        n_checks++; if (obs_stable_err !== 0) begin n_fail++; $display("[TB] FAIL wait_stable: got %0d violations want 0", obs_stable_err); end
        n_checks++; if (obs_upd_cnt !== 1) begin n_fail++; $display("[TB] FAIL wait_upd_pulses: got %0d want 1", obs_upd_cnt); end
        n_checks++; if (obs_valid_cnt !== 3) begin n_fail++; $display("[TB] FAIL wait_valid_cycles: got %0d want 3", obs_valid_cnt); end
        n_checks++; if (obs_instr !== mem_word(32'h2000)) begin n_fail++; $display("[TB] FAIL wait_instr: got %h want %h", obs_instr, mem_word(32'h2000)); end
        n_checks++; if (obs_cycles !== 9) begin n_fail++; $display("[TB] FAIL wait_cycles: got %0d want 9", obs_cycles); end
        n_checks++; if (obs_pc_next !== 32'h2004) begin n_fail++; $display("[TB] FAIL wait_pc_next: got %h want %h", obs_pc_next, 32'h2004); end
    endtask

    task automatic test_redirect_fetch();
        reset_and_load(32'h180);
        drive_one(2, 0, 1, 1, 32'h203, 32'h0);
        n_checks++; if (obs_pc_next !== 32'h200) begin n_fail++; $display("[TB] FAIL rfetch_pc_next: got %h want %h", obs_pc_next, 32'h200); end
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("[TB] FAIL rfetch_count: got %0d want 0", fetch_count); end
        n_checks++; if (obs_valid_cnt !== 0) begin n_fail++; $display("[TB] FAIL rfetch_valid: got %0d want 0", obs_valid_cnt); end
        n_checks++; if (obs_stable_err !== 0) begin n_fail++; $display("[TB] FAIL rfetch_req_held: got %0d violations want 0", obs_stable_err); end
        n_checks++; if (obs_cycles !== 5) begin n_fail++; $display("[TB] FAIL rfetch_cycles: got %0d want 5", obs_cycles); end
    endtask

    task automatic test_redirect_deliver();
        reset_and_load(32'h500);
        drive_one(0, 1, 2, 0, 32'h77D, 32'h0);
        n_checks++; if (obs_pc_next !== 32'h77C) begin n_fail++; $display("[TB] FAIL rdeliv_pc_next: got %h want %h", obs_pc_next, 32'h77C); end
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("[TB] FAIL rdeliv_count: got %0d want 0", fetch_count); end
        n_checks++; if (obs_valid_cnt !== 2) begin n_fail++; $display("[TB] FAIL rdeliv_valid_drop: got %0d want 2", obs_valid_cnt); end
    endtask

    task automatic test_last_wins();
        reset_and_load(32'h40);
        drive_one(2, 0, 3, 0, 32'h1111_1110, 32'h2222_2223);
        n_checks++; if (obs_pc_next !== 32'h2222_2220) begin n_fail++; $display("[TB] FAIL lastwins_pc_next: got %h want %h", obs_pc_next, 32'h2222_2220); end
    endtask

    task automatic test_wrap();
        reset_and_load(32'hFFFF_FFFC);
        drive_one(0, 0, 0, 0, 32'h0, 32'h0);
        n_checks++; if (obs_pc_next !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_pc_next: got %h want 0", obs_pc_next); end
        reset_and_load(32'h40);
        force dut.fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count;
        drive_one(0, 0, 0, 0, 32'h0, 32'h0);
        n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_count: got %h want 0", fetch_count); end
    endtask

    task automatic test_halt_reset();
        int bad;
        reset_and_load(32'h300);
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_halted: got %b want 1", halted); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            redirect = i[0]; redirect_target = 32'h800; halt = ~i[0]; imem_ack = 1'b1;
            step();
            if (imem_req !== 1'b0 || update_pc !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1) bad++;
        end
        redirect = 1'b0; halt = 1'b0; imem_ack = 1'b0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL halt_quiet: got %0d bad cycles want 0", bad); end
        reset_and_load(32'h400);
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin n_fail++; $display("[TB] FAIL rst_pre_fetch: got req %b addr %h want 1 %h", imem_req, imem_addr, 32'h400); end
        reset = 1'b1;
        step();
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        n_checks++; if ({pc_next, update_pc, imem_req, imem_addr, instr, instr_valid, halted, fetch_count} !== '0) begin
            n_fail++; $display("[TB] FAIL rst_mid_outputs: got req %b addr %h valid %b upd %b want all 0", imem_req, imem_addr, instr_valid, update_pc); end
        step();
        imem_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_late_ack: got valid %b instr %h want 0 0", instr_valid, instr); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_refetch: got req %b want 1", imem_req); end
    endtask

    task automatic test_random();
        int ack, rdy, mode, rc, expv, expc;
        logic [31:0] t1, t2, exp_next;
        reset_and_load($urandom & 32'hFFFF_FFFC);
        for (int n = 0; n < 40; n++) begin
            ack  = $urandom_range(0, 3);
            rdy  = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            rc   = $urandom_range(0, ack);
            t1   = $urandom;
            t2   = $urandom;
            drive_one(ack, rdy, mode, rc, t1, t2);
            if (mode == 3) exp_next = t2 & 32'hFFFF_FFFC;
            else if (mode != 0) exp_next = t1 & 32'hFFFF_FFFC;
            else exp_next = model_pc + 32'd4;
            expv = (mode == 0 || mode == 2) ? rdy + 1 : 0;
            expc = 3 + ack + expv;
            if (mode == 0) model_count = model_count + 32'd1;
            n_checks++; if (obs_addr !== model_pc) begin n_fail++; $display("[TB] FAIL rnd_addr[%0d]: got %h want %h", n, obs_addr, model_pc); end
            if (expv != 0) begin
                n_checks++; if (obs_instr !== mem_word(model_pc)) begin n_fail++; $display("[TB] FAIL rnd_instr[%0d]: got %h want %h", n, obs_instr, mem_word(model_pc)); end
            end
            n_checks++; if (obs_pc_next !== exp_next) begin n_fail++; $display("[TB] FAIL rnd_pc_next[%0d]: got %h want %h", n, obs_pc_next, exp_next); end
            n_checks++; if (fetch_count !== model_count) begin n_fail++; $display("[TB] FAIL rnd_count[%0d]: got %0d want %0d", n, fetch_count, model_count); end
            n_checks++; if (obs_valid_cnt !== expv) begin n_fail++; $display("[TB] FAIL rnd_valid[%0d]: got %0d want %0d", n, obs_valid_cnt, expv); end
            n_checks++; if (obs_cycles !== expc) begin n_fail++; $display("[TB] FAIL rnd_cycles[%0d]: got %0d want %0d", n, obs_cycles, expc); end
            n_checks++; if (obs_upd_cnt !== 1 || obs_stable_err !== 0) begin n_fail++; $display("[TB] FAIL rnd_protocol[%0d]: got upd %0d viol %0d want 1 0", n, obs_upd_cnt, obs_stable_err); end
            n_checks++; if (pc_cur !== exp_next) begin n_fail++; $display("[TB] FAIL rnd_pc_reg[%0d]: got %h want %h", n, pc_cur, exp_next); end
            model_pc = exp_next;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_redirect_fetch();
        test_redirect_deliver();
        test_last_wins();
        test_wrap();
        test_halt_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
